// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcodes, instruction field bit ranges and the stored decode word.
package cpu_isa_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int SH_HI  = 10;
   localparam int SH_LO  = 6;
   localparam int FN_HI  = 5;
   localparam int FN_LO  = 0;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;
   localparam int TGT_HI = 25;
   localparam int TGT_LO = 0;

   // Decoded instruction as held in the stage buffers; flags are one-hot.
   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [15:0] imm;
      logic [25:0] target;
      logic        is_r;
      logic        is_j;
      logic        is_i;
   } dec_t;

   localparam int DEC_W = $bits(dec_t);

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of a 32-bit instruction into its fields plus R/I/J classification.
module instr_field_split
   import cpu_isa_pkg::*;
(
   input  logic [31:0] instr,
   output dec_t        dec
);

   // Slice fields and classify by opcode; I-type is everything that is neither R nor J.
   always_comb begin
      dec        = '0;
      dec.opcode = instr[OPC_HI:OPC_LO];
      dec.rs     = instr[RS_HI:RS_LO];
      dec.rt     = instr[RT_HI:RT_LO];
      dec.rd     = instr[RD_HI:RD_LO];
      dec.shamt  = instr[SH_HI:SH_LO];
      dec.funct  = instr[FN_HI:FN_LO];
      dec.imm    = instr[IMM_HI:IMM_LO];
      dec.target = instr[TGT_HI:TGT_LO];
      dec.is_r   = (dec.opcode == OP_RTYPE);
      dec.is_j   = (dec.opcode == OP_J) || (dec.opcode == OP_JAL);
      dec.is_i   = !dec.is_r && !dec.is_j;
   end

endmodule

// File: rtl/if_id_decode_stage.sv
// IF/ID stage: main + skid buffer of pre-decoded instructions with registered in_ready.
module if_id_decode_stage
   import cpu_isa_pkg::*;
#(
   parameter int INSTR_WIDTH = 32,
   parameter int PC_WIDTH    = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_WIDTH-1:0] in_instr,
   input  logic [PC_WIDTH-1:0]    in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PC_WIDTH-1:0]    out_pc,
   output logic [5:0]             out_opcode,
   output logic [4:0]             out_rs,
   output logic [4:0]             out_rt,
   output logic [4:0]             out_rd,
   output logic [4:0]             out_shamt,
   output logic [5:0]             out_funct,
   output logic [15:0]            out_imm,
   output logic [25:0]            out_target,
   output logic                   out_is_r,
   output logic                   out_is_j,
   output logic                   out_is_i
);

   dec_t                in_dec;
   logic                accept;
   logic                retire;

   logic                main_v_q, main_v_d;
   logic                skid_v_q, skid_v_d;
   logic                in_ready_q, in_ready_d;
   dec_t                main_dec_q, main_dec_d;
   dec_t                skid_dec_q, skid_dec_d;
   logic [PC_WIDTH-1:0] main_pc_q, main_pc_d;
   logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;

   // Decode happens before capture so the outputs come straight from flops.
   instr_field_split u_split (
      .instr (in_instr),
      .dec   (in_dec)
   );

   assign accept = in_valid && in_ready_q;
   assign retire = main_v_q && out_ready;

   // Buffer steering: skid only fills when main stalls, and drains into main before new input.
   always_comb begin
      main_v_d   = main_v_q;
      skid_v_d   = skid_v_q;
      main_dec_d = main_dec_q;
      main_pc_d  = main_pc_q;
      skid_dec_d = skid_dec_q;
      skid_pc_d  = skid_pc_q;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (!main_v_q) begin
         if (accept) begin
            main_v_d   = 1'b1;
            main_dec_d = in_dec;
            main_pc_d  = in_pc;
         end
      end else if (retire) begin
         if (skid_v_q) begin
            // in_ready was low, so nothing new can arrive this cycle
            main_dec_d = skid_dec_q;
            main_pc_d  = skid_pc_q;
            skid_v_d   = 1'b0;
         end else if (accept) begin
            main_dec_d = in_dec;
            main_pc_d  = in_pc;
         end else begin
            main_v_d = 1'b0;
         end
      end else if (accept) begin
         skid_v_d   = 1'b1;
         skid_dec_d = in_dec;
         skid_pc_d  = in_pc;
      end
      in_ready_d = !skid_v_d;
   end

   // State registers; reset also clears the stored fields so outputs read zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         main_v_q   <= 1'b0;
         skid_v_q   <= 1'b0;
         in_ready_q <= 1'b1;
         main_dec_q <= '0;
         main_pc_q  <= '0;
         skid_dec_q <= '0;
         skid_pc_q  <= '0;
      end else begin
         main_v_q   <= main_v_d;
         skid_v_q   <= skid_v_d;
         in_ready_q <= in_ready_d;
         main_dec_q <= main_dec_d;
         main_pc_q  <= main_pc_d;
         skid_dec_q <= skid_dec_d;
         skid_pc_q  <= skid_pc_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = main_v_q;
   assign out_pc     = main_pc_q;
   assign out_opcode = main_dec_q.opcode;
   assign out_rs     = main_dec_q.rs;
   assign out_rt     = main_dec_q.rt;
   assign out_rd     = main_dec_q.rd;
   assign out_shamt  = main_dec_q.shamt;
   assign out_funct  = main_dec_q.funct;
   assign out_imm    = main_dec_q.imm;
   assign out_target = main_dec_q.target;
   assign out_is_r   = main_dec_q.is_r;
   assign out_is_j   = main_dec_q.is_j;
   assign out_is_i   = main_dec_q.is_i;

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Bench for if_id_decode_stage: FIFO-queue reference model plus directed literal checks.
module tb_if_id_decode_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [5:0]  out_opcode;
   logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
   logic [5:0]  out_funct;
   logic [15:0] out_imm;
   logic [25:0] out_target;
   logic        out_is_r, out_is_j, out_is_i;

   if_id_decode_stage #(.INSTR_WIDTH(32), .PC_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pc     (out_pc),
      .out_opcode (out_opcode),
      .out_rs     (out_rs),
      .out_rt     (out_rt),
      .out_rd     (out_rd),
      .out_shamt  (out_shamt),
      .out_funct  (out_funct),
      .out_imm    (out_imm),
      .out_target (out_target),
      .out_is_r   (out_is_r),
      .out_is_j   (out_is_j),
      .out_is_i   (out_is_i)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // Expected presented word, straight from the ISA field definitions.
   function automatic logic [127:0] ref_word(input logic [31:0] i, input logic [31:0] pc);
      logic [5:0] op;
      logic r, j;
      op = i[31:26];
      r  = (op == 6'h00);
      j  = (op == 6'h02) || (op == 6'h03);
      return 128'({pc, op, i[25:21], i[20:16], i[15:11], i[10:6], i[5:0],
                   i[15:0], i[25:0], r, j, !r && !j});
   endfunction

   logic [127:0] act_word;
   assign act_word = 128'({out_pc, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
                           out_imm, out_target, out_is_r, out_is_j, out_is_i});

   // Reference model: a 2-deep FIFO; ready whenever fewer than two are held.
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;
   ent_t q[$];

   always @(posedge clk) begin : model
      bit r, a;
      if (reset || flush) begin
         q.delete();
      end else begin
         r = (q.size() > 0) && out_ready;
         a = in_valid && (q.size() < 2);
         if (r) void'(q.pop_front());
         if (a) q.push_back('{in_instr, in_pc});
      end
   end

   // Per-cycle compare, and a log of what the DUT actually hands over.
   logic [31:0] ret_pc[$];
   int n_ret = 0;
   int n_acc = 0;
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
         chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
         if (q.size() > 0) chk("fields", act_word, ref_word(q[0].instr, q[0].pc));
         if (!reset && !flush) begin
            if (out_valid && out_ready) begin
               ret_pc.push_back(out_pc);
               n_ret++;
            end
            if (in_valid && in_ready) n_acc++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 3))
         0: w[31:26] = 6'h00;
         1: w[31:26] = 6'h02;
         2: w[31:26] = 6'h03;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      int base, errs, b_acc, b_ret;
      bit acc;

      // reset
      step();
      chk_en = 1'b1;
      step();
      step();
      chk("rst_valid", 128'(out_valid), 128'(0));
      chk("rst_ready", 128'(in_ready), 128'(1));
      chk("rst_fields", act_word, 128'(0));

      // single instructions
      reset = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h2128FFFC; in_pc = 32'h100;
      step();
      chk("addi_opc", 128'(out_opcode), 128'(6'h08));
      chk("addi_rs", 128'(out_rs), 128'(9));
      chk("addi_rt", 128'(out_rt), 128'(8));
      chk("addi_imm", 128'(out_imm), 128'(16'hFFFC));
      chk("addi_flags", 128'({out_is_r, out_is_j, out_is_i}), 128'(3'b001));
      in_instr = 32'h00221820; in_pc = 32'h104;
      step();
      chk("add_regs", 128'({out_rs, out_rt, out_rd, out_shamt}), 128'({5'd1, 5'd2, 5'd3, 5'd0}));
      chk("add_funct", 128'(out_funct), 128'(6'h20));
      chk("add_flags", 128'({out_is_r, out_is_j, out_is_i}), 128'(3'b100));
      in_instr = 32'h08000010; in_pc = 32'h108;
      step();
      chk("j_opc", 128'(out_opcode), 128'(6'h02));
      chk("j_target", 128'(out_target), 128'(26'h0000010));
      chk("j_flags", 128'({out_is_r, out_is_j, out_is_i}), 128'(3'b010));
      in_valid = 1'b0;
      step();
      chk("drain_valid", 128'(out_valid), 128'(0));

      // A,B,C with downstream stalled, then released
      base = ret_pc.size();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_instr = 32'h8C220004; in_pc = 32'h200; step();
      in_instr = 32'h0C000040; in_pc = 32'h204; step();
      in_instr = 32'h00431022; in_pc = 32'h208; step();
      chk("stall_ready", 128'(in_ready), 128'(0));
      chk("stall_pc", 128'(out_pc), 128'(32'h200));
      step();
      chk("hold_pc", 128'(out_pc), 128'(32'h200));
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         acc = in_valid && in_ready;
         step();
         if (acc && in_pc == 32'h208) in_valid = 1'b0;
      end
      chk("abc_count", 128'(ret_pc.size() - base), 128'(3));
      if (ret_pc.size() - base == 3) begin
         chk("abc_0", 128'(ret_pc[base]), 128'(32'h200));
         chk("abc_1", 128'(ret_pc[base + 1]), 128'(32'h204));
         chk("abc_2", 128'(ret_pc[base + 2]), 128'(32'h208));
      end
      chk("abc_ready", 128'(in_ready), 128'(1));

      // flush with main+skid full
      base = ret_pc.size();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_instr = 32'h20010001; in_pc = 32'h300; step();
      in_instr = 32'h20020002; in_pc = 32'h304; step();
      in_instr = 32'h20030003; in_pc = 32'h308; flush = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", 128'(out_valid), 128'(0));
      chk("fl_ready", 128'(in_ready), 128'(1));
      out_ready = 1'b1;
      repeat (3) step();
      chk("fl_none", 128'(ret_pc.size() - base), 128'(0));

      // flush with only main full: the same-cycle accept must be dropped
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_instr = 32'h20040004; in_pc = 32'h310; step();
      in_instr = 32'h20050005; in_pc = 32'h318; flush = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("fl2_valid", 128'(out_valid), 128'(0));
      repeat (2) step();
      chk("fl2_none", 128'(ret_pc.size() - base), 128'(0));

      // reset mid-operation with main+skid full
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_instr = 32'h20060006; in_pc = 32'h400; step();
      in_instr = 32'h20070007; in_pc = 32'h404; step();
      in_instr = 32'h20080008; in_pc = 32'h408; reset = 1'b1; flush = 1'b1; step();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
      chk("rs_valid", 128'(out_valid), 128'(0));
      chk("rs_ready", 128'(in_ready), 128'(1));
      chk("rs_fields", act_word, 128'(0));
      out_ready = 1'b1;
      repeat (3) step();
      chk("rs_none", 128'(ret_pc.size() - base), 128'(0));

      // 100 back-to-back with downstream always ready
      base = ret_pc.size();
      b_ret = n_ret;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_instr = rand_instr();
         in_pc = 32'h1000 + 32'(4 * i);
         step();
      end
      in_valid = 1'b0;
      step();
      chk("b2b_count", 128'(n_ret - b_ret), 128'(100));
      errs = 0;
      for (int i = 0; i < 100 && base + i < ret_pc.size(); i++)
         if (ret_pc[base + i] !== 32'h1000 + 32'(4 * i)) errs++;
      chk("b2b_order", 128'(errs), 128'(0));

      // random valid/ready: everything accepted comes out once, in order
      base = ret_pc.size();
      b_ret = n_ret;
      b_acc = n_acc;
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_instr = rand_instr();
         in_pc = 32'h4000 + 32'(4 * i);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      chk("rnd_count", 128'(n_ret - b_ret), 128'(n_acc - b_acc));
      errs = 0;
      for (int i = base + 1; i < ret_pc.size(); i++)
         if (ret_pc[i] <= ret_pc[i - 1]) errs++;
      chk("rnd_order", 128'(errs), 128'(0));
      chk("rnd_empty", 128'(out_valid), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
